// File: rtl/fpu_issue_sched.sv
// Issue scheduler for the variable-latency EXEC units (load, fdiv, fsqrt).
// Tracks GPR/FPR pending writes in a scoreboard and reserves the shared
// write-back port in a shifting reservation line whose slot 0 is the
// current write-back cycle.
module fpu_issue_sched #(
    parameter int unsigned LAT_LD   = 1,
    parameter int unsigned LAT_DIV  = 3,
    parameter int unsigned LAT_SQRT = 3
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_flush,
    input  logic       i_iss_valid,
    input  logic [1:0] i_iss_cls,
    input  logic       i_iss_dst_en,
    input  logic       i_iss_dst_fp,
    input  logic [4:0] i_iss_dst,
    input  logic       i_iss_sa_en,
    input  logic       i_iss_sa_fp,
    input  logic [4:0] i_iss_sa,
    input  logic       i_iss_sb_en,
    input  logic       i_iss_sb_fp,
    input  logic [4:0] i_iss_sb,
    output logic       o_iss_ready,
    output logic       o_stall,
    output logic       o_wb_valid,
    output logic [1:0] o_wb_cls,
    output logic       o_wb_dst_fp,
    output logic [4:0] o_wb_dst,
    output logic       o_busy
);

    localparam int unsigned LEN_A = (LAT_LD > LAT_DIV) ? LAT_LD : LAT_DIV;
    localparam int unsigned LEN   = (LEN_A > LAT_SQRT) ? LEN_A : LAT_SQRT;

    // Reservation line, packed per field; slot i writes back i cycles from now.
    // r_wen marks slots that really write a register (dst enabled, not GPR r0).
    logic [LEN-1:0]   r_vld, r_wen, r_fp;
    logic [2*LEN-1:0] r_cls;
    logic [5*LEN-1:0] r_dst;
    logic [31:0]      r_pend_gpr, r_pend_fpr;

    logic [LEN-1:0]   w_nxt_vld, w_nxt_wen, w_nxt_fp;
    logic [2*LEN-1:0] w_nxt_cls;
    logic [5*LEN-1:0] w_nxt_dst;
    logic [31:0]      w_nxt_pg, w_nxt_pf;
    int unsigned      w_lat;
    logic             w_wbv, w_raw, w_waw, w_port, w_accept_long, w_dst_wr;

    function automatic logic f_pend(input logic fp, input logic [4:0] idx,
                                    input logic [31:0] g, input logic [31:0] f);
        return fp ? f[idx] : g[idx];
    endfunction

    assign w_wbv       = r_vld[0] & r_wen[0];
    assign o_wb_valid  = w_wbv;
    assign o_wb_cls    = w_wbv ? r_cls[1:0] : 2'd0;
    assign o_wb_dst_fp = w_wbv ? r_fp[0]    : 1'b0;
    assign o_wb_dst    = w_wbv ? r_dst[4:0] : 5'd0;
    assign o_busy      = |r_vld;
    assign w_dst_wr    = i_iss_dst_en & (i_iss_dst_fp | (i_iss_dst != 5'd0));

    // Latency of the presented class.
    always_comb begin
        w_lat = 0;
        case (i_iss_cls)
            2'd0:    w_lat = 0;
            2'd1:    w_lat = LAT_LD;
            2'd2:    w_lat = LAT_DIV;
            default: w_lat = LAT_SQRT;
        endcase
    end

    // Hazard detection and issue handshake.
    // Short ops compete with the actual write in this cycle; long ops with the
    // reservation, so a dst-less long op still holds its port slot.
    always_comb begin
        w_raw  = (i_iss_sa_en && f_pend(i_iss_sa_fp, i_iss_sa, r_pend_gpr, r_pend_fpr)) ||
                 (i_iss_sb_en && f_pend(i_iss_sb_fp, i_iss_sb, r_pend_gpr, r_pend_fpr));
        w_waw  = i_iss_dst_en && f_pend(i_iss_dst_fp, i_iss_dst, r_pend_gpr, r_pend_fpr);
        w_port = 1'b0;
        if (w_lat == 0) begin
            w_port = w_wbv;
        end else begin
            for (int unsigned i = 0; i < LEN; i++) begin
                if (i == w_lat && r_vld[i]) w_port = 1'b1;
            end
        end
        o_iss_ready   = i_iss_valid && !i_flush && !w_raw && !w_waw && !w_port;
        o_stall       = i_iss_valid && !o_iss_ready;
        w_accept_long = o_iss_ready && (w_lat != 0);
    end

    // Next reservation line and scoreboard: shift, insert accepted long op,
    // retire the slot-0 write.
    always_comb begin
        w_nxt_vld = r_vld >> 1;
        w_nxt_wen = r_wen >> 1;
        w_nxt_fp  = r_fp  >> 1;
        w_nxt_cls = r_cls >> 2;
        w_nxt_dst = r_dst >> 5;
        w_nxt_pg  = r_pend_gpr;
        w_nxt_pf  = r_pend_fpr;
        if (w_wbv) begin
            if (r_fp[0]) w_nxt_pf[r_dst[4:0]] = 1'b0;
            else         w_nxt_pg[r_dst[4:0]] = 1'b0;
        end
        if (w_accept_long) begin
            for (int unsigned i = 0; i < LEN; i++) begin
                if (i + 1 == w_lat) begin
                    w_nxt_vld[i]         = 1'b1;
                    w_nxt_wen[i]         = w_dst_wr;
                    w_nxt_fp[i]          = i_iss_dst_fp;
                    w_nxt_cls[2*i +: 2]  = i_iss_cls;
                    w_nxt_dst[5*i +: 5]  = i_iss_dst;
                end
            end
            if (w_dst_wr) begin
                if (i_iss_dst_fp) w_nxt_pf[i_iss_dst] = 1'b1;
                else              w_nxt_pg[i_iss_dst] = 1'b1;
            end
        end
    end

    // State registers; flush and reset both discard everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld      <= '0;
            r_wen      <= '0;
            r_fp       <= '0;
            r_cls      <= '0;
            r_dst      <= '0;
            r_pend_gpr <= '0;
            r_pend_fpr <= '0;
        end else if (i_flush) begin
            r_vld      <= '0;
            r_wen      <= '0;
            r_fp       <= '0;
            r_cls      <= '0;
            r_dst      <= '0;
            r_pend_gpr <= '0;
            r_pend_fpr <= '0;
        end else begin
            r_vld      <= w_nxt_vld;
            r_wen      <= w_nxt_wen;
            r_fp       <= w_nxt_fp;
            r_cls      <= w_nxt_cls;
            r_dst      <= w_nxt_dst;
            r_pend_gpr <= w_nxt_pg;
            r_pend_fpr <= w_nxt_pf;
        end
    end

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Directed bench for fpu_issue_sched (LAT_LD=1, LAT_DIV=3, LAT_SQRT=3).
module tb_fpu_issue_sched;

    typedef struct packed {
        logic       v;
        logic [1:0] cls;
        logic       den;
        logic       dfp;
        logic [4:0] dst;
        logic       aen;
        logic       afp;
        logic [4:0] a;
        logic       ben;
        logic       bfp;
        logic [4:0] b;
    } op_t;

    typedef struct packed {
        logic       rdy;
        logic       wbv;
        logic [1:0] cls;
        logic       wfp;
        logic [4:0] wdst;
        logic       busy;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t ex;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] cls = '0;
    logic       den = 1'b0, dfp = 1'b0, aen = 1'b0, afp = 1'b0, ben = 1'b0, bfp = 1'b0;
    logic [4:0] dst = '0, sa = '0, sb = '0;
    logic       iss_ready, stall, wb_valid, wb_dst_fp, busy;
    logic [1:0] wb_cls;
    logic [4:0] wb_dst;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    vec_t        vecs[$];

    op_t Q, fdiv3, fadd4, fadd_ind, fsqrt6, lw7, fmul9, lw0, add1, fmov3, fdivx, lw4;

    always #5 clk = ~clk;

    fpu_issue_sched #(.LAT_LD(1), .LAT_DIV(3), .LAT_SQRT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_iss_valid(valid), .i_iss_cls(cls),
        .i_iss_dst_en(den), .i_iss_dst_fp(dfp), .i_iss_dst(dst),
        .i_iss_sa_en(aen), .i_iss_sa_fp(afp), .i_iss_sa(sa),
        .i_iss_sb_en(ben), .i_iss_sb_fp(bfp), .i_iss_sb(sb),
        .o_iss_ready(iss_ready), .o_stall(stall),
        .o_wb_valid(wb_valid), .o_wb_cls(wb_cls), .o_wb_dst_fp(wb_dst_fp),
        .o_wb_dst(wb_dst), .o_busy(busy)
    );

    function automatic op_t OP(input logic [1:0] c, input logic e, input logic f,
                               input logic [4:0] d, input logic ae, input logic af,
                               input logic [4:0] a, input logic be, input logic bf,
                               input logic [4:0] b);
        op_t o;
        o.v = 1'b1; o.cls = c; o.den = e; o.dfp = f; o.dst = d;
        o.aen = ae; o.afp = af; o.a = a; o.ben = be; o.bfp = bf; o.b = b;
        return o;
    endfunction

    function automatic exp_t EX(input logic r, input logic w, input logic [1:0] c,
                                input logic f, input logic [4:0] d, input logic bz);
        exp_t x;
        x.rdy = r; x.wbv = w; x.cls = c; x.wfp = f; x.wdst = d; x.busy = bz;
        return x;
    endfunction

    function automatic vec_t V(input op_t o, input exp_t x);
        vec_t t;
        t.op = o;
        t.ex = x;
        return t;
    endfunction

    task automatic drive(input op_t o);
        valid = o.v; cls = o.cls; den = o.den; dfp = o.dfp; dst = o.dst;
        aen = o.aen; afp = o.afp; sa = o.a; ben = o.ben; bfp = o.bfp; sb = o.b;
    endtask

    task automatic chk(input string nm, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [vec %0d]: got %0h, expected %0h", nm, idx, act, exp);
    endtask

    task automatic expect_out(input int idx, input logic v, input exp_t x);
        chk("iss_ready", idx, {7'd0, iss_ready}, {7'd0, x.rdy});
        chk("stall",     idx, {7'd0, stall},     {7'd0, v & ~x.rdy});
        chk("wb_valid",  idx, {7'd0, wb_valid},  {7'd0, x.wbv});
        chk("wb_cls",    idx, {6'd0, wb_cls},    {6'd0, x.cls});
        chk("wb_dst_fp", idx, {7'd0, wb_dst_fp}, {7'd0, x.wfp});
        chk("wb_dst",    idx, {3'd0, wb_dst},    {3'd0, x.wdst});
        chk("busy",      idx, {7'd0, busy},      {7'd0, x.busy});
    endtask

    // One vector per cycle: drive after the falling edge, check 1ns later.
    task automatic step(input int idx, input op_t o, input exp_t x);
        drive(o);
        #1;
        expect_out(idx, o.v, x);
        @(negedge clk);
    endtask

    initial begin
        Q        = '0;
        fdiv3    = OP(2'd2, 1, 1, 5'd3,  1, 1, 5'd1,  1, 1, 5'd2);
        fadd4    = OP(2'd0, 1, 1, 5'd4,  1, 1, 5'd3,  1, 1, 5'd5);
        fadd_ind = OP(2'd0, 1, 1, 5'd4,  1, 1, 5'd1,  1, 1, 5'd2);
        fsqrt6   = OP(2'd3, 1, 1, 5'd6,  1, 1, 5'd7,  0, 0, 5'd0);
        lw7      = OP(2'd1, 1, 0, 5'd7,  1, 0, 5'd2,  0, 0, 5'd0);
        fmul9    = OP(2'd0, 1, 1, 5'd9,  1, 1, 5'd10, 1, 1, 5'd11);
        lw0      = OP(2'd1, 1, 0, 5'd0,  1, 0, 5'd2,  0, 0, 5'd0);
        add1     = OP(2'd0, 1, 0, 5'd1,  1, 0, 5'd0,  1, 0, 5'd0);
        fmov3    = OP(2'd0, 1, 1, 5'd3,  1, 1, 5'd8,  0, 0, 5'd0);
        fdivx    = OP(2'd2, 0, 1, 5'd12, 1, 1, 5'd1,  1, 1, 5'd2);
        lw4      = OP(2'd1, 1, 0, 5'd4,  1, 0, 5'd2,  0, 0, 5'd0);

        // RAW on fdiv result: stall through the wb cycle, accept after
        vecs.push_back(V(fdiv3, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(fadd4, EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(fadd4, EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(fadd4, EX(0, 1, 2, 1, 3, 1)));
        vecs.push_back(V(fadd4, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 0)));
        // fdiv, fsqrt, lw: port conflicts push lw to t4
        vecs.push_back(V(fdiv3,  EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(fsqrt6, EX(1, 0, 0, 0, 0, 1)));
        vecs.push_back(V(lw7,    EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(lw7,    EX(0, 1, 2, 1, 3, 1)));
        vecs.push_back(V(lw7,    EX(1, 1, 3, 1, 6, 1)));
        vecs.push_back(V(Q,      EX(0, 1, 1, 0, 7, 1)));
        vecs.push_back(V(Q,      EX(0, 0, 0, 0, 0, 0)));
        // short op blocked by write in its own cycle
        vecs.push_back(V(fdiv3, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(fmul9, EX(0, 1, 2, 1, 3, 1)));
        vecs.push_back(V(fmul9, EX(1, 0, 0, 0, 0, 0)));
        // load to r0 never pends and never writes
        vecs.push_back(V(lw0,  EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(add1, EX(1, 0, 0, 0, 0, 1)));
        vecs.push_back(V(Q,    EX(0, 0, 0, 0, 0, 0)));
        // WAW, including during the wb cycle
        vecs.push_back(V(fdiv3, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(fmov3, EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(fmov3, EX(0, 1, 2, 1, 3, 1)));
        vecs.push_back(V(fmov3, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 0)));
        // dst-less fdiv still reserves its port slot
        vecs.push_back(V(fdivx, EX(1, 0, 0, 0, 0, 0)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(lw4,   EX(0, 0, 0, 0, 0, 1)));
        vecs.push_back(V(lw4,   EX(1, 0, 0, 0, 0, 1)));
        vecs.push_back(V(Q,     EX(0, 1, 1, 0, 4, 1)));
        vecs.push_back(V(Q,     EX(0, 0, 0, 0, 0, 0)));

        // reset state
        #2;
        expect_out(-1, 1'b0, EX(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step(i, vecs[i].op, vecs[i].ex);

        // flush one cycle after fdiv: no wb, f3 free afterwards
        step(100, fdiv3, EX(1, 0, 0, 0, 0, 0));
        flush = 1'b1;
        step(101, fadd_ind, EX(0, 0, 0, 0, 0, 1));
        flush = 1'b0;
        step(102, fadd4, EX(1, 0, 0, 0, 0, 0));
        step(103, Q,     EX(0, 0, 0, 0, 0, 0));
        step(104, Q,     EX(0, 0, 0, 0, 0, 0));

        // async reset while fdiv is in flight
        step(200, fdiv3, EX(1, 0, 0, 0, 0, 0));
        drive(Q);
        #1;
        expect_out(201, 1'b0, EX(0, 0, 0, 0, 0, 1));
        rst_n = 1'b0;
        #1;
        expect_out(202, 1'b0, EX(0, 0, 0, 0, 0, 0));
        drive(fadd4);
        #1;
        expect_out(203, 1'b1, EX(1, 0, 0, 0, 0, 0));
        drive(Q);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) step(210 + k, Q, EX(0, 0, 0, 0, 0, 0));
        step(220, fadd4, EX(1, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
